// File: rtl/ram64x8_burst_writer_if.sv
// Burst-write host bus for the 64x8 RAM: start/length request,
// valid/ready byte stream and completion status.
interface ram64x8_burst_writer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   burst_len;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  modport master (
    output start, start_addr, burst_len,
    output wr_valid, wr_data,
    input  wr_ready, busy, done, wr_count
  );

  modport slave (
    input  start, start_addr, burst_len,
    input  wr_valid, wr_data,
    output wr_ready, busy, done, wr_count
  );
endinterface

// File: rtl/ram64x8_burst_writer.sv
// 64x8 RAM filled by a burst-write engine (auto-incrementing,
// wrapping pointer) with a registered read-before-write read port.
module ram64x8_burst_writer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ram64x8_burst_writer_if.slave bus,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  // Power-up image is the identity table; reset leaves it alone.
  mem_t mem_q = mem_init();

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W:0]   cnt_q;
  logic              rdy_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_q;
  logic              xfer;

  assign xfer = (state_q == WRITE) && bus.wr_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q <= '0;
            if (bus.burst_len != '0) begin
              ptr_q   <= bus.start_addr;
              rem_q   <= bus.burst_len;
              state_q <= WRITE;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            rem_q <= rem_q - (ADDR_W+1)'(1);
            cnt_q <= cnt_q + (ADDR_W+1)'(1);
            if (rem_q == (ADDR_W+1)'(1)) begin
              state_q <= DONE;
              rdy_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && xfer) mem_q[ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= mem_q[rd_addr];
  end

  assign bus.wr_ready = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_count = cnt_q;
  assign rd_data      = rd_q;
endmodule

// File: tb/tb_ram64x8_burst_writer.sv
// Directed bench for ram64x8_burst_writer: reference memory image
// plus a read-back scoreboard queue.
module tb_ram64x8_burst_writer;
  logic       clk;
  logic       reset;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  ram64x8_burst_writer_if bus ();

  ram64x8_burst_writer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_mem [64];
  logic [7:0] sb [$];
  logic [7:0] src [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [5:0] a);
    sb.push_back(exp_mem[a]);
    rd_addr = a;
    step();
    chk($sformatf("rd[%0d]", a), rd_data, sb.pop_front());
  endtask

  // vmask bit c is wr_valid in stimulus cycle c; mid >= 0 pulses start there.
  task automatic burst(input string tag, input logic [5:0] a,
                       input logic [6:0] len, input int ncyc,
                       input logic [31:0] vmask, input int mid);
    int         n = 0;
    logic [5:0] p = a;
    int         rdy_n = 0;
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.burst_len  = len;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bus.wr_valid = vmask[c];
      bus.wr_data  = (n < src.size()) ? src[n] : 8'h00;
      if (c == mid) begin
        bus.start      = 1'b1;
        bus.start_addr = 6'd0;
        bus.burst_len  = 7'd2;
      end
      if (bus.wr_ready === 1'b1) rdy_n++;
      chk({tag, ".busy"}, bus.busy, 1);
      chk({tag, ".done_early"}, bus.done, 0);
      step();
      bus.start = 1'b0;
      if (vmask[c]) begin
        exp_mem[p] = src[n];
        p++;
        n++;
      end
    end
    bus.wr_valid = 1'b0;
    chk({tag, ".ready_cycles"}, rdy_n, ncyc);
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".ready_off"}, bus.wr_ready, 0);
    chk({tag, ".busy_off"}, bus.busy, 0);
    chk({tag, ".count"}, bus.wr_count, len);
    step();
    chk({tag, ".done_pulse"}, bus.done, 0);
    chk({tag, ".idle_busy"}, bus.busy, 0);
    chk({tag, ".idle_ready"}, bus.wr_ready, 0);
    chk({tag, ".count_hold"}, bus.wr_count, len);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i);
    reset          = 1'b1;
    rd_addr        = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.burst_len  = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;

    // 1: reset state and initial contents
    step();
    step();
    chk("rst.rd_data", rd_data, 0);
    chk("rst.ready", bus.wr_ready, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.count", bus.wr_count, 0);
    reset = 1'b0;
    rd(6'd5);

    // 2: basic burst
    src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    burst("b4", 6'd10, 7'd4, 4, 32'hF, -1);
    for (int a = 10; a <= 14; a++) rd(6'(a));

    // 3: address wrap
    src = '{8'd11, 8'd22, 8'd33, 8'd44};
    burst("wrap", 6'd62, 7'd4, 4, 32'hF, -1);
    rd(6'd62);
    rd(6'd63);
    rd(6'd0);
    rd(6'd1);
    rd(6'd2);

    // 4: backpressure 1,0,0,1,0,1 with start pulsed mid-burst
    src = '{8'hC0, 8'hC1, 8'hC2};
    burst("bp", 6'd30, 7'd3, 6, 32'b101001, 2);
    for (int a = 30; a <= 33; a++) rd(6'(a));
    rd(6'd0);

    // 5: zero-length burst
    bus.start      = 1'b1;
    bus.start_addr = 6'd50;
    bus.burst_len  = 7'd0;
    step();
    bus.start = 1'b0;
    chk("z.done", bus.done, 1);
    chk("z.busy", bus.busy, 0);
    chk("z.ready", bus.wr_ready, 0);
    chk("z.count", bus.wr_count, 0);
    step();
    chk("z.done_pulse", bus.done, 0);
    chk("z.busy2", bus.busy, 0);
    rd(6'd50);

    // 6: reset mid-burst
    bus.start      = 1'b1;
    bus.start_addr = 6'd20;
    bus.burst_len  = 7'd5;
    step();
    bus.start    = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hB0;
    step();
    exp_mem[20]  = 8'hB0;
    bus.wr_data  = 8'hB1;
    step();
    exp_mem[21]  = 8'hB1;
    chk("rm.count2", bus.wr_count, 2);
    bus.wr_data  = 8'hB2;
    reset        = 1'b1;
    step();
    chk("rm.busy", bus.busy, 0);
    chk("rm.ready", bus.wr_ready, 0);
    chk("rm.count", bus.wr_count, 0);
    chk("rm.done", bus.done, 0);
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    step();
    chk("rm.done2", bus.done, 0);
    rd(6'd20);
    rd(6'd21);
    rd(6'd22);

    chk("sb.empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram64x8_burst_writer.md
Name: ram64x8_burst_writer

Overview:
Write-side counterpart to the team's 64x8 lookup ROM: a 64x8 RAM filled by a burst-write engine. A host issues start with an address and length, then streams bytes over a valid/ready handshake. Bytes land at auto-incrementing, wrapping addresses. A registered read port, with the same timing as the ROM's read, lets the consumer or bench read contents back.

Parameters:
ADDR_W, 6, address width; depth = 2**ADDR_W = 64 words
DATA_W, 8, word width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  burst request; sampled only in IDLE
start_addr  in  ADDR_W  first write address, captured with start
burst_len  in  ADDR_W+1  bytes in burst, 0..64, captured with start
wr_valid  in  1  wr_data holds a valid byte
wr_data  in  DATA_W  write byte
wr_ready  out  1  engine accepts a byte this cycle
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
wr_count  out  ADDR_W+1  bytes accepted in current or last burst
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data

Behaviour:
- Reset (reset=1 at clk edge):
  - state=IDLE; wr_ready=0, busy=0, done=0, wr_count=0, rd_data=0.
  - Internal pointer and remaining count are cleared.
  - Memory contents are not cleared.
- Memory power-up/initial contents: mem[i]=i for i=0..63.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - Outputs: wr_ready=0, busy=0.
  - start=1 and burst_len!=0: capture ptr=start_addr and rem=burst_len, clear wr_count, go to WRITE.
  - start=1 and burst_len==0: clear wr_count, go to DONE; no write occurs.
- WRITE:
  - Outputs: wr_ready=1, busy=1.
  - Transfer occurs when wr_valid and wr_ready are both 1 at a clock edge. On a transfer:
    - mem[ptr] <= wr_data
    - ptr <= ptr+1 mod 64 (63 wraps to 0)
    - rem <= rem-1
    - wr_count <= wr_count+1
  - Transfer with rem==1: go to DONE.
  - wr_valid=0: no change; stall is unbounded.
- DONE:
  - Outputs: done=1 for exactly one cycle, busy=0, wr_ready=0.
  - Next state: IDLE.
  - start in DONE is ignored.
- Outputs wr_ready, busy and done are decoded from registered state only; none depend combinationally on inputs.
- start while busy (WRITE) is ignored; start_addr and burst_len are not re-captured.
- burst_len > 64 is illegal; the bench does not drive it. Behaviour is unspecified beyond no lock-up, since rem is the full ADDR_W+1 bits.
- burst_len=64 overwrites every location exactly once, ending back at start_addr.
- wr_count holds its final value after done until the next accepted start or reset.
- Read port:
  - rd_data <= mem[rd_addr] every cycle that reset=0; 1-cycle latency.
  - Read and write to the same address in the same cycle return the old data (read-before-write). The new data is visible on the following read.
- Reset mid-burst:
  - Abort immediately: state=IDLE, no done pulse, wr_count=0.
  - Bytes already written stay in memory.
- Latency:
  - start to first possible transfer: 1 cycle.
  - Last transfer to done high: 1 cycle.
  - Continuous valid: 1 byte per cycle.

Test Plan:
1. Reset, then rd_addr=5 -> rd_data=5 one cycle later. Also wr_ready=0, busy=0, done=0, wr_count=0.
2. start, start_addr=10, burst_len=4, wr_valid held high with A0,A1,A2,A3:
   - wr_ready high exactly 4 cycles; done pulses the cycle after the 4th transfer; wr_count=4.
   - Read-back: 10..13 -> A0..A3, and address 14 -> 14.
3. Wrap: start_addr=62, burst_len=4, data 11,22,33,44 -> mem[62]=11, mem[63]=22, mem[0]=33, mem[1]=44; mem[2]=2 unchanged.
4. Backpressure plus ignored start: burst_len=3, wr_valid pattern 1,0,0,1,0,1, and start pulsed mid-burst with start_addr=0.
   - Exactly 3 writes at the original addresses; done 1 cycle after the 6th stimulus cycle; no new burst starts.
5. burst_len=0: start at cycle N -> done=1 at N+1, busy never high, wr_count=0, no memory change.
6. Reset mid-burst: start_addr=20, burst_len=5, reset asserted after 2 transfers (B0,B1).
   - Next cycle: busy=0, wr_ready=0, wr_count=0; no done pulse.
   - Read-back: mem[20]=B0, mem[21]=B1, mem[22]=22.
